// File: rtl/mw_writeback_stage.sv
// MEM->WB pipeline register with load-data extension and GRF write-port drive.
// Optional MW_EXC_KILL_EN: suppress the GPR write of instructions captured with a nonzero exccode_M.
module mw_writeback_stage #(
    parameter logic [31:0] DEV_LO = 32'h0000_7f00,
    parameter logic [31:0] DEV_HI = 32'h0000_7f1b,
    parameter logic [31:0] PC_RST = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] PC_M,
    input  logic [31:0] IR_M,
    input  logic [31:0] ALU_M,
    input  logic [31:0] dm_rd_M,
    input  logic [31:0] dev_rd_M,
    input  logic [31:0] cp0_rd_M,
    input  logic [4:0]  A3_M,
    input  logic        RegWE_M,
    input  logic [1:0]  WDSel_M,
    input  logic [4:0]  exccode_M,
    output logic [31:0] PC_W,
    output logic [31:0] IR_W,
    output logic [4:0]  A3_W,
    output logic [31:0] WD_W,
    output logic        RegWE_W,
    output logic [31:0] retire_cnt
);

    logic [31:0] ALU_W;
    logic [31:0] rd_W;
    logic [31:0] cp0_W;
    logic [1:0]  WDSel_W;
    logic [31:0] rd_sel_M;
    logic        we_cap_M;
    logic [31:0] load_W;

    // Byte/half/word select with sign or zero extension; low address bits are trusted as given.
    function automatic logic [31:0] load_extend(input logic [5:0] op, input logic [1:0] lo,
                                                input logic [31:0] word);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] b_sx;
        logic signed [31:0] h_sx;
        b    = word[8*lo +: 8];
        h    = lo[1] ? word[31:16] : word[15:0];
        b_sx = b;
        h_sx = h;
        case (op)
            6'b100011: load_extend = word;
            6'b100001: load_extend = h_sx;
            6'b100101: load_extend = {16'h0000, h};
            6'b100000: load_extend = b_sx;
            6'b100100: load_extend = {24'h000000, b};
            default:   load_extend = word;
        endcase
    endfunction

    assign rd_sel_M = (ALU_M >= DEV_LO && ALU_M <= DEV_HI) ? dev_rd_M : dm_rd_M;

`ifdef MW_EXC_KILL_EN
    assign we_cap_M = RegWE_M && (exccode_M == 5'd0);
`else
    logic exc_unused;
    assign exc_unused = |exccode_M;
    assign we_cap_M   = RegWE_M;
`endif

    // M -> W boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            PC_W       <= PC_RST;
            IR_W       <= 32'h0;
            A3_W       <= 5'd0;
            RegWE_W    <= 1'b0;
            retire_cnt <= 32'h0;
            ALU_W      <= 32'h0;
            rd_W       <= 32'h0;
            cp0_W      <= 32'h0;
            WDSel_W    <= 2'b00;
        end else begin
            PC_W    <= PC_M;
            ALU_W   <= ALU_M;
            rd_W    <= rd_sel_M;
            cp0_W   <= cp0_rd_M;
            WDSel_W <= WDSel_M;
            if (flush) begin
                IR_W    <= 32'h0;
                RegWE_W <= 1'b0;
                A3_W    <= 5'd0;
            end else begin
                IR_W    <= IR_M;
                RegWE_W <= we_cap_M;
                A3_W    <= we_cap_M ? A3_M : 5'd0;
                if (IR_M != 32'h0)
                    retire_cnt <= retire_cnt + 32'd1;
            end
        end
    end

    assign load_W = load_extend(IR_W[31:26], ALU_W[1:0], rd_W);

    always_comb begin
        WD_W = ALU_W;
        case (WDSel_W)
            2'b00: WD_W = ALU_W;
            2'b01: WD_W = load_W;
            2'b10: WD_W = PC_W + 32'd8;
            2'b11: WD_W = cp0_W;
            default: WD_W = ALU_W;
        endcase
    end

endmodule
